// File: rtl/pck_inj_sched.sv
// pck_inj_sched: round-robin packet injection scheduler with per-source FWFT queues
// and a start/drain/done run sequencer with injection statistics.
module pck_inj_sched #(
  parameter int NSRC     = 4,
  parameter int DATAw    = 32,
  parameter int PCK_SIZw = 8,
  parameter int NEw      = 6,
  parameter int QDEPTH   = 4,
  localparam int SRCw    = $clog2(NSRC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NSRC-1:0]          src_valid,
  input  logic [NSRC*DATAw-1:0]    src_id,
  input  logic [NSRC*PCK_SIZw-1:0] src_size,
  input  logic [NSRC*NEw-1:0]      src_dest,
  input  logic [NSRC-1:0]          src_end,
  output logic [NSRC-1:0]          src_ready,
  input  logic                     inj_ready,
  output logic                     inj_pck_wr,
  output logic [DATAw-1:0]         inj_data,
  output logic [PCK_SIZw-1:0]      inj_size,
  output logic [NEw-1:0]           inj_dest,
  output logic [SRCw-1:0]          inj_src,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              sent_pck_cnt,
  output logic [31:0]              sent_flit_cnt,
  output logic [31:0]              stall_cnt,
  output logic [15:0]              drop_cnt
);
  localparam int QAw = $clog2(QDEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t                r_state;
  logic [NSRC-1:0]       r_end;
  logic [SRCw-1:0]       r_ptr;
  logic [QAw:0]          r_wp [NSRC];
  logic [QAw:0]          r_rp [NSRC];
  logic [DATAw-1:0]      r_qid [NSRC][QDEPTH];
  logic [PCK_SIZw-1:0]   r_qsize [NSRC][QDEPTH];
  logic [NEw-1:0]        r_qdest [NSRC][QDEPTH];
  logic [NSRC-1:0]       w_empty, w_full, w_elig, w_push, w_pop, w_drop, w_end;
  logic [SRCw-1:0]       w_gnt, w_idx;
  logic [QAw-1:0]        w_head;
  logic                  w_any, w_run, w_act;
  logic [SRCw:0]         w_ndrop;
  logic [16:0]           w_drop_sum;

  assign w_run = r_state == RUN;
  assign w_act = r_state == RUN || r_state == DRAIN;
  assign w_end = r_end | src_end;

  // src_ready looks only at registered queue state, never at this cycle's pop
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      w_empty[s]   = r_wp[s] == r_rp[s];
      w_full[s]    = r_wp[s] == {~r_rp[s][QAw], r_rp[s][QAw-1:0]};
      src_ready[s] = w_run & ~r_end[s] & ~w_full[s];
      w_drop[s]    = src_valid[s] & src_ready[s] & (src_size[s*PCK_SIZw +: PCK_SIZw] == '0);
      w_push[s]    = src_valid[s] & src_ready[s] & ~w_drop[s];
      w_elig[s]    = w_act & ~w_empty[s];
    end
  end

  // descending scan so the nearest eligible index after r_ptr is the last one written
  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int i = NSRC; i > 0; i--) begin
      w_idx = SRCw'((int'(r_ptr) + i) % NSRC);
      if (w_elig[w_idx]) begin
        w_gnt = w_idx;
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NSRC; s++) w_pop[s] = inj_pck_wr & (w_gnt == SRCw'(s));
  end

  assign w_head     = r_rp[w_gnt][QAw-1:0];
  assign inj_pck_wr = w_any & inj_ready;
  assign inj_data   = inj_pck_wr ? r_qid[w_gnt][w_head] : '0;
  assign inj_size   = inj_pck_wr ? r_qsize[w_gnt][w_head] : '0;
  assign inj_dest   = inj_pck_wr ? r_qdest[w_gnt][w_head] : '0;
  assign inj_src    = inj_pck_wr ? w_gnt : '0;
  assign busy       = w_act;
  assign done       = r_state == DONE;
  assign w_ndrop    = (SRCw+1)'($countones(w_drop));
  assign w_drop_sum = {1'b0, drop_cnt} + 17'(w_ndrop);

  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++) begin
      if (w_push[s]) begin
        r_qid[s][r_wp[s][QAw-1:0]]   <= src_id[s*DATAw +: DATAw];
        r_qsize[s][r_wp[s][QAw-1:0]] <= src_size[s*PCK_SIZw +: PCK_SIZw];
        r_qdest[s][r_wp[s][QAw-1:0]] <= src_dest[s*NEw +: NEw];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NSRC; s++) begin
        r_wp[s] <= '0;
        r_rp[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (w_push[s]) r_wp[s] <= r_wp[s] + 1'b1;
        if (w_pop[s]) r_rp[s] <= r_rp[s] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_end         <= '0;
      r_ptr         <= SRCw'(NSRC-1);
      sent_pck_cnt  <= '0;
      sent_flit_cnt <= '0;
      stall_cnt     <= '0;
      drop_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state       <= RUN;
          r_end         <= '0;
          r_ptr         <= SRCw'(NSRC-1);
          sent_pck_cnt  <= '0;
          sent_flit_cnt <= '0;
          stall_cnt     <= '0;
          drop_cnt      <= '0;
        end
        RUN: begin
          r_end <= w_end;
          if (&w_end) r_state <= DRAIN;
        end
        DRAIN: if (&w_empty && !inj_pck_wr) r_state <= DONE;
        default: r_state <= IDLE;
      endcase
      if (w_act) begin
        if (inj_pck_wr) begin
          r_ptr         <= w_gnt;
          sent_pck_cnt  <= sent_pck_cnt + 32'd1;
          sent_flit_cnt <= sent_flit_cnt + 32'(inj_size);
        end
        if (w_any && !inj_ready) stall_cnt <= stall_cnt + 32'd1;
        drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
    end
  end
endmodule

// File: doc/pck_inj_sched.md
Name: pck_inj_sched

Overview:
Per-endpoint injection scheduler between NSRC traffic sources (synthetic-trace ports, DPI feeders, class generators) and one packet_injector.
- Each source has a small FWFT queue.
- A round-robin arbiter issues one packet per accepted cycle while the injector is ready.
- A start/drain/done FSM sequences the traffic run and counts injected packets, flits and stall cycles.

Parameters:
NSRC, 4, number of sources; 2..16
DATAw, 32, packet id/data width
PCK_SIZw, 8, packet size field width (flits)
NEw, 6, destination endpoint id width
QDEPTH, 4, per-source queue depth in packets; power of 2, ≥2
SRCw, log2(NSRC), source index width; derived, not overridable

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  pulse: begin or restart a run
src_valid  in  NSRC  per-source request
src_id  in  NSRC*DATAw  packet id, source s at [s*DATAw +: DATAw]
src_size  in  NSRC*PCK_SIZw  packet size in flits
src_dest  in  NSRC*NEw  destination endpoint id
src_end  in  NSRC  source has no more traffic; level or pulse
src_ready  out  NSRC  queue s accepts this cycle
inj_ready  in  1  packet_injector ready
inj_pck_wr  out  1  inject packet this cycle
inj_data  out  DATAw  head id of granted source
inj_size  out  PCK_SIZw  head size
inj_dest  out  NEw  head destination
inj_src  out  SRCw  granted source index (used as class_num)
busy  out  1  FSM in RUN or DRAIN
done  out  1  FSM in DONE
sent_pck_cnt  out  32  packets injected this run
sent_flit_cnt  out  32  flits injected this run
stall_cnt  out  32  cycles with ≥1 non-empty queue and inj_ready=0
drop_cnt  out  16  zero-size requests rejected this run

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE.
  - All queues empty; end flags cleared; RR pointer=NSRC-1, so source 0 wins first.
  - All counters 0; src_ready=0, inj_pck_wr=0, busy=0, done=0.
  - inj_data/size/dest/src=0.
- FSM:
  - IDLE: start=1 -> RUN.
  - RUN: end_flag[s] set sticky when src_end[s]=1. When all end_flag are set (including the cycle they become set) -> DRAIN.
  - DRAIN: when all queues are empty and no grant is issued this cycle -> DONE.
  - DONE: start=1 -> RUN. Clears end flags, counters and RR pointer; queues are already empty.
  - start in RUN or DRAIN is ignored.
- Accept:
  - src_ready[s] = (state==RUN) & ~end_flag[s] & ~full[s]. It depends only on registered state, not on same-cycle pop.
  - Push when src_valid[s] & src_ready[s].
  - src_end[s] and src_valid[s] in the same cycle: packet accepted, flag set.
- Zero-size request (src_size=0) with src_ready=1: not queued; drop_cnt+1, saturating at 16'hFFFF.
- Queue: FWFT, QDEPTH entries. A push at cycle t is visible at the head at t+1. Simultaneous push and pop are both performed. A full queue is never written.
- Arbitration (combinational, same cycle):
  - Eligible = non-empty queues, in state RUN or DRAIN.
  - Grant the first eligible index after the RR pointer, searching circularly.
  - inj_pck_wr = eligible_any & inj_ready.
  - inj_* = head of granted queue when inj_pck_wr=1, else 0.
  - On inj_pck_wr: pop granted queue, RR pointer <= granted index.
  - inj_ready=0: no pop, pointer held.
- Latency: request at cycle t with empty queues and inj_ready=1 -> inj_pck_wr at t+1. Throughput is 1 packet/cycle total.
- Counters (RUN/DRAIN only, 32-bit wrap):
  - sent_pck_cnt +1 per inj_pck_wr.
  - sent_flit_cnt += inj_size, zero-extended.
  - stall_cnt +1 per cycle where eligible_any & ~inj_ready.
  - Counters hold in DONE until the next start.
- busy=1 in RUN/DRAIN; done=1 in DONE only.
- Reset mid-run discards queued packets; no injection may occur in the cycle reset is asserted.

Test Plan:
1. Single source: start; src0 pushes id=0xA5, size=3, dest=5 at cycle t, inj_ready=1 -> at t+1 inj_pck_wr=1, inj_data=0xA5, inj_size=3, inj_dest=5, inj_src=0. Afterwards sent_pck_cnt=1, sent_flit_cnt=3.
2. Round-robin: all 4 sources each queue 2 packets, inj_ready=1 -> grant order 0,1,2,3,0,1,2,3 on 8 consecutive cycles.
3. Backpressure: src1 pushes 4 packets with inj_ready=0 -> src_ready[1]=0 after the 4th push. The 5th request is not accepted. stall_cnt increments each cycle; raise inj_ready -> 4 injections, stall_cnt frozen.
4. Drain/done: queue 3 packets on src2, assert src_end on all sources, inj_ready=0 for 5 cycles -> busy=1, done=0, src_ready=0. Release inj_ready -> 3 injections, then done=1 one cycle after the last pop.
5. Zero-size: src0 size=0 -> no queue entry, drop_cnt=1, no inj_pck_wr.
6. Async reset mid-DRAIN with 2 packets queued -> outputs and counters immediately 0, FSM IDLE. After reset release, no injection occurs until start and a new push.
